// File: rtl/packet_filter_pkg.sv
// Shared types for the store-and-forward packet filter.
//   drop_reason_t : verdict attached to each buffered packet
//   pf_desc_t     : descriptor queued per packet {reason, channel, stored_words}
//   state_t       : egress FSM states
// The descriptor field widths follow PfChannelW / PfMaxWords. packet_filter_mc takes its
// CHANNEL_W / MAX_WORDS defaults from them, so keep any override in line with these values.
package packet_filter_pkg;

   localparam int unsigned PfChannelW = 2;
   localparam int unsigned PfMaxWords = 190;
   localparam int unsigned PfCntW     = $clog2(PfMaxWords + 1);

   typedef enum logic [1:0] {
      RsnNone,
      RsnChan,
      RsnLen,
      RsnFrame
   } drop_reason_t;

   typedef struct packed {
      drop_reason_t            reason;
      logic [PfChannelW-1:0]   channel;
      logic [PfCntW-1:0]       stored_words;
   } pf_desc_t;

   typedef enum logic [1:0] {
      StIdle,
      StFwd,
      StDrop
   } state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: data/sop/eop/empty/channel with valid/ready handshake.
//   master : drives the beat, receives ready (egress side of a block)
//   slave  : receives the beat, drives ready (ingress side of a block)
interface avalon_st_if #(
   parameter int unsigned DWIDTH    = 64,
   parameter int unsigned CHANNEL_W = 2
);
   localparam int unsigned EMPTY_W = $clog2(DWIDTH / 8);

   logic [DWIDTH-1:0]    data;
   logic                 sop;
   logic                 eop;
   logic [EMPTY_W-1:0]   empty;
   logic [CHANNEL_W-1:0] channel;
   logic                 valid;
   logic                 ready;

   modport master (output data, sop, eop, empty, channel, valid, input ready);
   modport slave  (input data, sop, eop, empty, channel, valid, output ready);

endinterface

// File: rtl/pf_sync_fifo.sv
// Show-ahead single-clock FIFO: rdata_o always presents the head entry while not empty.
//   clk_i, arst_n_i : clock, asynchronous active-low reset (pointers only)
//   push_i, wdata_i : write; ignored when full
//   pop_i           : drop head entry; ignored when empty
//   rdata_o         : head entry
//   full_o, empty_o : status
module pf_sync_fifo #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              push_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DWIDTH-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DWIDTH-1:0] mem_q [2**AWIDTH];
   logic [AWIDTH:0]   wptr_q;
   logic [AWIDTH:0]   rptr_q;
   logic              do_push;
   logic              do_pop;

   // Extra pointer bit tells full from empty when the address bits match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
                    (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q[AWIDTH-1:0]];

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[AWIDTH-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/packet_filter_mc.sv
// Store-and-forward multi-channel packet filter. Each ingress packet is buffered whole in a
// data FIFO with a descriptor in a second FIFO; the egress FSM then forwards or drains it
// according to the descriptor verdict and the channel-enable mask.
//   clk_i, arst_n_i   : clock, asynchronous active-low reset
//   sink_if (slave)   : ingress Avalon-ST stream
//   src_if  (master)  : egress Avalon-ST stream, honours backpressure
//   chan_en_i         : per-channel pass enable, sampled when a packet is decided
//   fwd_cnt_o, drop_chan_cnt_o, drop_len_cnt_o, drop_frame_cnt_o : packet statistics
// Build option: define PF_STATS_EN to build the four wrapping statistics counters;
// otherwise the counter outputs are tied to zero.
module packet_filter_mc
   import packet_filter_pkg::*;
#(
   parameter int unsigned DWIDTH    = 64,
   parameter int unsigned CHANNEL_W = PfChannelW,
   parameter int unsigned DF_AWIDTH = 9,
   parameter int unsigned SF_AWIDTH = 6,
   parameter int unsigned MIN_WORDS = 8,
   parameter int unsigned MAX_WORDS = PfMaxWords
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   avalon_st_if.slave            sink_if,
   avalon_st_if.master           src_if,
   input  logic [2**CHANNEL_W-1:0] chan_en_i,
   output logic [31:0]           fwd_cnt_o,
   output logic [31:0]           drop_chan_cnt_o,
   output logic [31:0]           drop_len_cnt_o,
   output logic [31:0]           drop_frame_cnt_o
);

   localparam int unsigned EMPTY_W = $clog2(DWIDTH / 8);
   localparam int unsigned CNT_W   = $clog2(MAX_WORDS + 1);
   localparam int unsigned DF_W    = DWIDTH + 2 + EMPTY_W;
   localparam int unsigned SF_W    = $bits(pf_desc_t);

   // Word counter is one bit wider so it can saturate at MAX_WORDS+1 for any MAX_WORDS.
   localparam logic [CNT_W:0]   MinW      = (CNT_W + 1)'(MIN_WORDS);
   localparam logic [CNT_W:0]   MaxW      = (CNT_W + 1)'(MAX_WORDS);
   localparam logic [CNT_W:0]   MaxW1     = (CNT_W + 1)'(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] MaxStored = CNT_W'(MAX_WORDS);

   // ---------------- FIFOs ----------------
   logic            df_push, df_pop, df_full, df_empty;
   logic [DF_W-1:0] df_rdata;
   logic            sf_push, sf_pop, sf_full, sf_empty;
   pf_desc_t        sf_wdata, sf_head;
   logic [SF_W-1:0] sf_rdata;

   pf_sync_fifo #(.DWIDTH(DF_W), .AWIDTH(DF_AWIDTH)) u_data_fifo (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .push_i   (df_push),
      .wdata_i  ({sink_if.data, sink_if.sop, sink_if.eop, sink_if.empty}),
      .pop_i    (df_pop),
      .rdata_o  (df_rdata),
      .full_o   (df_full),
      .empty_o  (df_empty)
   );

   pf_sync_fifo #(.DWIDTH(SF_W), .AWIDTH(SF_AWIDTH)) u_desc_fifo (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .push_i   (sf_push),
      .wdata_i  (sf_wdata),
      .pop_i    (sf_pop),
      .rdata_o  (sf_rdata),
      .full_o   (sf_full),
      .empty_o  (sf_empty)
   );

   assign sf_head = pf_desc_t'(sf_rdata);

   // ---------------- Ingress ----------------
   logic                 rdy_q;
   logic                 in_pkt_q, in_pkt_d;
   logic [CNT_W:0]       wcnt_q, wcnt_d;
   logic [CHANNEL_W-1:0] chan_q, chan_d;
   logic                 pend_q, pend_d;
   pf_desc_t             pend_desc_q, pend_desc_d;
   logic                 sink_ready, beat, start, cont, close_old, close_new;
   logic [CNT_W:0]       cur_words, wcnt_new;
   pf_desc_t             new_desc, old_desc;

   // rdy_q keeps ready low while in reset; pend_q stalls for the second descriptor push.
   assign sink_ready    = rdy_q & ~df_full & ~sf_full & ~pend_q;
   assign sink_if.ready = sink_ready;

   always_comb begin
      beat      = sink_if.valid & sink_ready;
      start     = beat & sink_if.sop;
      cont      = beat & ~sink_if.sop & in_pkt_q;
      cur_words = sink_if.sop ? '0 : wcnt_q;
      wcnt_new  = (cur_words == MaxW1) ? cur_words : cur_words + 1'b1;
      df_push   = (start | cont) & (cur_words < MaxW);
      close_old = start & in_pkt_q;
      close_new = (start | cont) & sink_if.eop;

      new_desc.reason       = (wcnt_new < MinW || wcnt_new > MaxW) ? RsnLen : RsnNone;
      new_desc.channel      = sink_if.sop ? sink_if.channel : chan_q;
      new_desc.stored_words = (wcnt_new > MaxW) ? MaxStored : wcnt_new[CNT_W-1:0];
      old_desc.reason       = RsnFrame;
      old_desc.channel      = chan_q;
      old_desc.stored_words = (wcnt_q > MaxW) ? MaxStored : wcnt_q[CNT_W-1:0];

      sf_push     = 1'b0;
      sf_wdata    = new_desc;
      pend_d      = pend_q;
      pend_desc_d = pend_desc_q;
      if (pend_q) begin
         sf_push  = ~sf_full;
         sf_wdata = pend_desc_q;
         pend_d   = sf_full;
      end else if (close_old) begin
         // A sop+eop beat inside an open packet closes two packets at once: the new
         // descriptor is parked and pushed next cycle while ingress stalls.
         sf_push  = 1'b1;
         sf_wdata = old_desc;
         if (close_new) begin
            pend_d      = 1'b1;
            pend_desc_d = new_desc;
         end
      end else if (close_new) begin
         sf_push = 1'b1;
      end

      in_pkt_d = in_pkt_q;
      wcnt_d   = wcnt_q;
      chan_d   = chan_q;
      if (start | cont) begin
         in_pkt_d = ~sink_if.eop;
         wcnt_d   = wcnt_new;
      end
      if (start) chan_d = sink_if.channel;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rdy_q       <= 1'b0;
         in_pkt_q    <= 1'b0;
         wcnt_q      <= '0;
         chan_q      <= '0;
         pend_q      <= 1'b0;
         pend_desc_q <= '0;
      end else begin
         rdy_q       <= 1'b1;
         in_pkt_q    <= in_pkt_d;
         wcnt_q      <= wcnt_d;
         chan_q      <= chan_d;
         pend_q      <= pend_d;
         pend_desc_q <= pend_desc_d;
      end
   end

   // ---------------- Egress ----------------
   state_t               state_q;
   logic [CNT_W-1:0]     rcnt_q;
   logic [CHANNEL_W-1:0] out_chan_q;
   logic                 go_fwd;

   assign go_fwd = (sf_head.reason == RsnNone) & chan_en_i[sf_head.channel];
   assign sf_pop = (state_q == StIdle) & ~sf_empty;
   assign df_pop = ~df_empty & (((state_q == StFwd) & src_if.ready) | (state_q == StDrop));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= StIdle;
         rcnt_q     <= '0;
         out_chan_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sf_pop) begin
                  rcnt_q     <= sf_head.stored_words;
                  out_chan_q <= sf_head.channel;
                  state_q    <= go_fwd ? StFwd : StDrop;
               end
            end
            StFwd, StDrop: begin
               if (df_pop) begin
                  rcnt_q <= rcnt_q - 1'b1;
                  if (rcnt_q == CNT_W'(1)) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign src_if.valid   = (state_q == StFwd);
   assign src_if.data    = df_rdata[DF_W-1 -: DWIDTH];
   assign src_if.sop     = df_rdata[EMPTY_W + 1];
   assign src_if.eop     = df_rdata[EMPTY_W];
   assign src_if.empty   = df_rdata[EMPTY_W-1:0];
   assign src_if.channel = out_chan_q;

   // ---------------- Statistics ----------------
`ifdef PF_STATS_EN
   logic [31:0] fwd_q, chan_q_cnt, len_q, frame_q;
   logic        stray, dec_frame;

   // Stray beats (no sop, outside a packet) are discarded and each counts as a framing drop.
   assign stray     = beat & ~sink_if.sop & ~in_pkt_q;
   assign dec_frame = sf_pop & (sf_head.reason == RsnFrame);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         fwd_q      <= '0;
         chan_q_cnt <= '0;
         len_q      <= '0;
         frame_q    <= '0;
      end else begin
         if (sf_pop) begin
            if (go_fwd)                            fwd_q      <= fwd_q + 32'd1;
            else if (sf_head.reason == RsnNone)    chan_q_cnt <= chan_q_cnt + 32'd1;
            else if (sf_head.reason == RsnLen)     len_q      <= len_q + 32'd1;
         end
         frame_q <= frame_q + 32'(dec_frame) + 32'(stray);
      end
   end

   assign fwd_cnt_o        = fwd_q;
   assign drop_chan_cnt_o  = chan_q_cnt;
   assign drop_len_cnt_o   = len_q;
   assign drop_frame_cnt_o = frame_q;
`else
   assign fwd_cnt_o        = 32'd0;
   assign drop_chan_cnt_o  = 32'd0;
   assign drop_len_cnt_o   = 32'd0;
   assign drop_frame_cnt_o = 32'd0;
`endif

endmodule
